// File: rtl/uart_pkg.sv
// Shared UART definitions: parity codes, TX/RX state encodings, default oversample.
// Imported by uart_tick_gen and uart_param_core.
package uart_pkg;

  localparam int OS_DEFAULT = 16;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  // Code 11 is treated as no parity.
  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Prescaler: one-clock tick every div+1 clocks, restarted by clr.
// Ports: clk, rst (sync, high), clr, div[DIV_W], tick.
module uart_tick_gen
  import uart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // >= rather than == so a divisor lowered mid-count cannot stall.
  assign tick = (cnt_q >= div);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    if (clr) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_param_core.sv
// Full-duplex UART with runtime divisor/parity/stop and 16x-oversampled RX.
// Ports: clk, rst, cfg_*, wr_en/data_in/busy/tx, rx/data_out/rdy/rdy_clr, error flags.
module uart_param_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 16,
  parameter int OS        = OS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_W-1:0]     cfg_div,
  input  logic [1:0]           cfg_parity,
  input  logic                 cfg_stop2,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 busy,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rdy,
  input  logic                 rdy_clr,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int TW = $clog2(OS);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_LAST = TW'(OS - 1);
  localparam logic [TW-1:0] T_HALF = TW'(OS / 2 - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  // ---------------- TX ----------------
  tx_state_e tx_state_q, tx_state_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic [BW-1:0] tx_bit_q, tx_bit_d;
  logic [TW-1:0] tx_tcnt_q, tx_tcnt_d;
  logic tx_par_q, tx_par_d;
  logic tx_stop_q, tx_stop_d;
  logic tx_q, tx_d;
  logic busy_q, busy_d;
  logic tx_clr, tx_tick, tx_end;

  uart_tick_gen #(.DIV_W(DIV_W)) u_tx_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tx_clr),
    .div  (cfg_div),
    .tick (tx_tick)
  );

  assign tx_end = tx_tick && (tx_tcnt_q == T_LAST);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_sh_d    = tx_sh_q;
    tx_bit_d   = tx_bit_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_par_d   = tx_par_q;
    tx_stop_d  = tx_stop_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    tx_clr     = 1'b0;
    if (tx_state_q != TX_IDLE && tx_tick)
      tx_tcnt_d = tx_end ? '0 : tx_tcnt_q + 1'b1;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (wr_en) begin
          tx_state_d = TX_START;
          tx_sh_d    = data_in;
          tx_par_d   = (^data_in) ^ (cfg_parity == PAR_ODD);
          tx_bit_d   = '0;
          tx_tcnt_d  = '0;
          tx_stop_d  = 1'b0;
          tx_clr     = 1'b1;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end
      end
      TX_START: if (tx_end) begin
        tx_state_d = TX_DATA;
        tx_d       = tx_sh_q[0];
      end
      TX_DATA: if (tx_end) begin
        tx_sh_d = tx_sh_q >> 1;
        if (tx_bit_q == B_LAST) begin
          if (par_enabled(cfg_parity)) begin
            tx_state_d = TX_PARITY;
            tx_d       = tx_par_q;
          end else begin
            tx_state_d = TX_STOP;
            tx_d       = 1'b1;
          end
        end else begin
          tx_bit_d = tx_bit_q + 1'b1;
          tx_d     = tx_sh_q[1];
        end
      end
      TX_PARITY: if (tx_end) begin
        tx_state_d = TX_STOP;
        tx_d       = 1'b1;
      end
      TX_STOP: if (tx_end) begin
        if (tx_stop_q || !cfg_stop2) begin
          tx_state_d = TX_IDLE;
          busy_d     = 1'b0;
        end else begin
          tx_stop_d = 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_sh_q    <= '0;
      tx_bit_q   <= '0;
      tx_tcnt_q  <= '0;
      tx_par_q   <= 1'b0;
      tx_stop_q  <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_sh_q    <= tx_sh_d;
      tx_bit_q   <= tx_bit_d;
      tx_tcnt_q  <= tx_tcnt_d;
      tx_par_q   <= tx_par_d;
      tx_stop_q  <= tx_stop_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

  // ---------------- RX ----------------
  rx_state_e rx_state_q, rx_state_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic [BW-1:0] rx_bit_q, rx_bit_d;
  logic [TW-1:0] rx_tcnt_q, rx_tcnt_d;
  logic rx_s1_q, rx_s2_q, rx_prev_q;
  logic rx_perr_f_q, rx_perr_f_d;
  logic rx_ferr_f_q, rx_ferr_f_d;
  logic rx_done_q, rx_done_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic rdy_q, rdy_d;
  logic perr_q, perr_d;
  logic ferr_q, ferr_d;
  logic ovr_q, ovr_d;
  logic rx_clr, rx_tick, rx_fall, rx_half, rx_full;

  uart_tick_gen #(.DIV_W(DIV_W)) u_rx_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (rx_clr),
    .div  (cfg_div),
    .tick (rx_tick)
  );

  assign rx_fall = rx_prev_q & ~rx_s2_q;
  assign rx_half = rx_tick && (rx_tcnt_q == T_HALF);
  assign rx_full = rx_tick && (rx_tcnt_q == T_LAST);

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_sh_d     = rx_sh_q;
    rx_bit_d    = rx_bit_q;
    rx_tcnt_d   = rx_tcnt_q;
    rx_perr_f_d = rx_perr_f_q;
    rx_ferr_f_d = rx_ferr_f_q;
    rx_done_d   = 1'b0;
    rx_clr      = 1'b0;
    if (rx_tick) rx_tcnt_d = rx_tcnt_q + 1'b1;
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_tcnt_d = '0;
        if (rx_fall) begin
          rx_state_d  = RX_START;
          rx_clr      = 1'b1;
          rx_bit_d    = '0;
          rx_perr_f_d = 1'b0;
          rx_ferr_f_d = 1'b0;
        end
      end
      // Mid-start sample; a high line here is a glitch, not a frame.
      RX_START: if (rx_half) begin
        rx_tcnt_d  = '0;
        rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_full) begin
        rx_tcnt_d = '0;
        rx_sh_d   = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
        if (rx_bit_q == B_LAST)
          rx_state_d = par_enabled(cfg_parity) ? RX_PARITY : RX_STOP;
        else
          rx_bit_d = rx_bit_q + 1'b1;
      end
      RX_PARITY: if (rx_full) begin
        rx_tcnt_d   = '0;
        rx_perr_f_d = rx_s2_q ^ (^rx_sh_q) ^ (cfg_parity == PAR_ODD);
        rx_state_d  = RX_STOP;
      end
      RX_STOP: if (rx_full) begin
        rx_tcnt_d   = '0;
        rx_ferr_f_d = ~rx_s2_q;
        rx_done_d   = 1'b1;
        rx_state_d  = rx_s2_q ? RX_IDLE : RX_BREAK;
      end
      // Line held low (break): re-arm only once it returns high.
      RX_BREAK: begin
        rx_tcnt_d = '0;
        if (rx_s2_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Completion beats a same-cycle rdy_clr, which only drops the old history.
  always_comb begin
    data_out_d = data_out_q;
    rdy_d      = rdy_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    ovr_d      = ovr_q;
    if (rx_done_q) begin
      data_out_d = rx_sh_q;
      rdy_d      = 1'b1;
      perr_d     = rx_perr_f_q | (perr_q & ~rdy_clr);
      ferr_d     = rx_ferr_f_q | (ferr_q & ~rdy_clr);
      ovr_d      = (rdy_q | ovr_q) & ~rdy_clr;
    end else if (rdy_clr) begin
      rdy_d  = 1'b0;
      perr_d = 1'b0;
      ferr_d = 1'b0;
      ovr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_sh_q     <= '0;
      rx_bit_q    <= '0;
      rx_tcnt_q   <= '0;
      rx_perr_f_q <= 1'b0;
      rx_ferr_f_q <= 1'b0;
      rx_done_q   <= 1'b0;
      data_out_q  <= '0;
      rdy_q       <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      rx_s1_q     <= rx;
      rx_s2_q     <= rx_s1_q;
      rx_prev_q   <= rx_s2_q;
      rx_state_q  <= rx_state_d;
      rx_sh_q     <= rx_sh_d;
      rx_bit_q    <= rx_bit_d;
      rx_tcnt_q   <= rx_tcnt_d;
      rx_perr_f_q <= rx_perr_f_d;
      rx_ferr_f_q <= rx_ferr_f_d;
      rx_done_q   <= rx_done_d;
      data_out_q  <= data_out_d;
      rdy_q       <= rdy_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
    end
  end

  assign data_out   = data_out_q;
  assign rdy        = rdy_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_param_core.sv
// Self-checking bench for uart_param_core (8-bit and 7-bit instances).
// Frame-level reference model; randomized loopback and driven frames.
module tb_uart_param_core;
  import uart_pkg::*;

  localparam int OS = 16;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic rst8, rst7, wr_en, rdy_clr, cfg_stop2, loop_en, rx_drv, sel;
  logic [15:0] cfg_div;
  logic [1:0] cfg_parity;
  logic [7:0] data_in;

  logic tx8, busy8, rdy8, perr8, ferr8, ovr8;
  logic [7:0] dout8;
  logic tx7, busy7, rdy7, perr7, ferr7, ovr7;
  logic [6:0] dout7;

  logic rx8, wr8, wr7;
  logic tx_m, busy_m, rdy_m, perr_m, ferr_m, ovr_m;
  logic [7:0] dout_m;

  assign rx8    = loop_en ? tx8 : rx_drv;
  assign wr8    = wr_en & ~sel;
  assign wr7    = wr_en & sel;
  assign tx_m   = sel ? tx7 : tx8;
  assign busy_m = sel ? busy7 : busy8;
  assign rdy_m  = sel ? rdy7 : rdy8;
  assign perr_m = sel ? perr7 : perr8;
  assign ferr_m = sel ? ferr7 : ferr8;
  assign ovr_m  = sel ? ovr7 : ovr8;
  assign dout_m = sel ? {1'b0, dout7} : dout8;

  uart_param_core #(.DATA_BITS(8), .DIV_W(16), .OS(OS)) dut8 (
    .clk(clk), .rst(rst8), .cfg_div(cfg_div), .cfg_parity(cfg_parity),
    .cfg_stop2(cfg_stop2), .wr_en(wr8), .data_in(data_in), .busy(busy8),
    .tx(tx8), .rx(rx8), .data_out(dout8), .rdy(rdy8), .rdy_clr(rdy_clr),
    .parity_err(perr8), .frame_err(ferr8), .overrun(ovr8)
  );

  uart_param_core #(.DATA_BITS(7), .DIV_W(16), .OS(OS)) dut7 (
    .clk(clk), .rst(rst7), .cfg_div(cfg_div), .cfg_parity(cfg_parity),
    .cfg_stop2(cfg_stop2), .wr_en(wr7), .data_in(data_in[6:0]), .busy(busy7),
    .tx(tx7), .rx(tx7), .data_out(dout7), .rdy(rdy7), .rdy_clr(rdy_clr),
    .parity_err(perr7), .frame_err(ferr7), .overrun(ovr7)
  );

  int checks = 0;
  int failures = 0;
  int db = 8;
  logic frame_q[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bp();
    return OS * (int'(cfg_div) + 1);
  endfunction

  function automatic logic par_on(input logic [1:0] m);
    return (m == 2'b01) || (m == 2'b10);
  endfunction

  // Parity bit from the count of ones in the data word.
  function automatic logic model_par(input logic [7:0] d, input int nb,
                                     input logic [1:0] m);
    int ones;
    ones = 0;
    for (int i = 0; i < nb; i++) ones += int'(d[i]);
    if (m == 2'b10) return (ones % 2) == 0;
    return (ones % 2) == 1;
  endfunction

  task automatic build(input logic [7:0] d, input int nb, input logic [1:0] m,
                       input logic pbit, input logic stop_v, input logic two);
    frame_q.delete();
    frame_q.push_back(1'b0);
    for (int i = 0; i < nb; i++) frame_q.push_back(d[i]);
    if (par_on(m)) frame_q.push_back(pbit);
    frame_q.push_back(stop_v);
    if (two) frame_q.push_back(1'b1);
  endtask

  task automatic send_and_check(input logic [7:0] d, input int poke);
    int p, n, c, bc;
    p = bp();
    build(d, db, cfg_parity, model_par(d, db, cfg_parity), 1'b1, cfg_stop2);
    n = frame_q.size();
    @(negedge clk);
    data_in = d;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    c = 0;
    bc = 0;
    while (busy_m === 1'b1 && c < n * p + 4 * p) begin
      if (c % p == p / 2 && c / p < n)
        chk($sformatf("tx_bit%0d", c / p), tx_m, frame_q[c / p]);
      if (c == poke) begin
        data_in = ~d;
        wr_en = 1'b1;
      end
      if (c == poke + 1) wr_en = 1'b0;
      bc++;
      c++;
      @(negedge clk);
    end
    wr_en = 1'b0;
    chk("busy_len", bc, n * p);
  endtask

  task automatic wait_rdy(input string tag);
    int k;
    k = 0;
    while (rdy_m !== 1'b1 && k < 8 * bp()) begin
      @(negedge clk);
      k++;
    end
    chk(tag, rdy_m, 1);
  endtask

  task automatic expect_rx(input string tag, input logic [7:0] d,
                           input logic pe, input logic fe, input logic ov);
    logic [7:0] mask;
    mask = (db == 7) ? 8'h7f : 8'hff;
    chk({tag, "_data"}, dout_m, d & mask);
    chk({tag, "_perr"}, perr_m, pe);
    chk({tag, "_ferr"}, ferr_m, fe);
    chk({tag, "_ovr"}, ovr_m, ov);
  endtask

  task automatic clr_rdy();
    @(negedge clk);
    rdy_clr = 1'b1;
    @(negedge clk);
    rdy_clr = 1'b0;
  endtask

  task automatic drive(input logic [7:0] d, input logic pbit,
                       input logic stop_v, input logic hold_low);
    int p;
    p = bp();
    build(d, 8, cfg_parity, pbit, stop_v, 1'b0);
    foreach (frame_q[i]) begin
      rx_drv = frame_q[i];
      repeat (p) @(negedge clk);
    end
    if (!hold_low) rx_drv = 1'b1;
  endtask

  initial begin
    logic [7:0] d;
    logic pb;
    rst8 = 1'b1; rst7 = 1'b1; wr_en = 1'b0; rdy_clr = 1'b0;
    cfg_stop2 = 1'b0; loop_en = 1'b1; rx_drv = 1'b1; sel = 1'b0;
    cfg_div = 16'd3; cfg_parity = 2'b00; data_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx8, 1);
    chk("rst_busy", busy8, 0);
    chk("rst_rdy", rdy8, 0);
    chk("rst_dout", dout8, 0);
    chk("rst_flags", {perr8, ferr8, ovr8}, 0);
    rst8 = 1'b0;
    rst7 = 1'b0;
    repeat (2) @(negedge clk);

    // 8N1 loopback
    send_and_check(8'hAB, -1);
    wait_rdy("lb_ab_rdy");
    expect_rx("lb_ab", 8'hAB, 0, 0, 0);
    clr_rdy();
    chk("clr_rdy", rdy8, 0);
    send_and_check(8'h55, -1);
    wait_rdy("lb_55_rdy");
    expect_rx("lb_55", 8'h55, 0, 0, 0);
    clr_rdy();

    // Driven parity frames
    loop_en = 1'b0;
    cfg_parity = 2'b01;
    drive(8'h55, 1'b1, 1'b1, 1'b0);
    wait_rdy("pe_even_rdy");
    expect_rx("pe_even", 8'h55, 1'b1 != model_par(8'h55, 8, 2'b01), 0, 0);
    clr_rdy();
    cfg_parity = 2'b10;
    drive(8'h55, 1'b1, 1'b1, 1'b0);
    wait_rdy("pe_odd_rdy");
    expect_rx("pe_odd", 8'h55, 1'b1 != model_par(8'h55, 8, 2'b10), 0, 0);
    clr_rdy();

    // Framing error then break
    cfg_parity = 2'b00;
    drive(8'hA5, 1'b0, 1'b0, 1'b1);
    wait_rdy("fe_rdy");
    expect_rx("fe", 8'hA5, 0, 1, 0);
    clr_rdy();
    repeat (3 * bp()) @(negedge clk);
    chk("break_no_rdy", rdy8, 0);
    rx_drv = 1'b1;
    repeat (bp()) @(negedge clk);
    drive(8'h3C, 1'b0, 1'b1, 1'b0);
    wait_rdy("after_break_rdy");
    expect_rx("after_break", 8'h3C, 0, 0, 0);
    clr_rdy();

    // Overrun
    loop_en = 1'b1;
    send_and_check(8'h11, -1);
    send_and_check(8'h22, -1);
    wait_rdy("ovr_rdy");
    expect_rx("ovr", 8'h22, 0, 0, 1);
    clr_rdy();
    chk("ovr_clr", {rdy8, ovr8, perr8, ferr8}, 0);

    // False start
    loop_en = 1'b0;
    rx_drv = 1'b0;
    repeat ((OS / 2 - 2) * (int'(cfg_div) + 1)) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2 * bp()) @(negedge clk);
    chk("false_start", rdy8, 0);
    d = 8'($urandom);
    drive(d, 1'b0, 1'b1, 1'b0);
    wait_rdy("post_glitch_rdy");
    expect_rx("post_glitch", d, 0, 0, 0);
    clr_rdy();

    // Random loopback frames
    loop_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cfg_div = 16'($urandom_range(0, 2));
      cfg_parity = 2'($urandom_range(0, 3));
      cfg_stop2 = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      send_and_check(d, -1);
      wait_rdy($sformatf("rnd%0d_rdy", i));
      expect_rx($sformatf("rnd%0d", i), d, 0, 0, 0);
      clr_rdy();
    end

    // Random driven frames with random parity bit
    loop_en = 1'b0;
    cfg_stop2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cfg_div = 16'($urandom_range(0, 2));
      cfg_parity = 2'($urandom_range(0, 3));
      d = 8'($urandom);
      pb = 1'($urandom_range(0, 1));
      drive(d, pb, 1'b1, 1'b0);
      wait_rdy($sformatf("drv%0d_rdy", i));
      expect_rx($sformatf("drv%0d", i), d,
                par_on(cfg_parity) && (pb != model_par(d, 8, cfg_parity)),
                0, 0);
      clr_rdy();
    end

    // 7-bit, odd parity, two stop bits
    sel = 1'b1;
    db = 7;
    cfg_div = 16'd1;
    cfg_parity = 2'b10;
    cfg_stop2 = 1'b1;
    send_and_check(8'h7F, -1);
    wait_rdy("b7_rdy");
    expect_rx("b7", 8'h7F, 0, 0, 0);
    clr_rdy();
    send_and_check(8'h2A, 3 * bp());
    repeat (2) @(negedge clk);
    chk("b7_no_queue", busy7, 0);
    wait_rdy("b7_poke_rdy");
    expect_rx("b7_poke", 8'h2A, 0, 0, 0);
    clr_rdy();

    // Reset mid-DATA
    @(negedge clk);
    data_in = 8'h33;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (3 * bp()) @(negedge clk);
    chk("mid_busy", busy7, 1);
    rst7 = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx", tx7, 1);
    chk("mid_rst_busy", busy7, 0);
    rst7 = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_param_core.md
Name: uart_param_core

Overview:
Parametrised full-duplex UART core, the next generation of the uart_top transmitter/receiver pair. It adds the following over uart_top:
- configurable data width
- runtime baud divisor
- runtime parity mode and stop-bit count
- 16x-oversampled receiver with false-start rejection
- parity, framing and overrun error reporting

It sits between the host register interface and the serial pins. Its handshake matches uart_top: wr_en/busy on transmit, rdy/rdy_clr on receive.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- DIV_W, 16, width of cfg_div.
- OS, 16, oversample ticks per bit; must be even and >= 4.

Ports:
- clk  in  1  core clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cfg_div  in  DIV_W  prescaler: one tick every cfg_div+1 clocks; bit period = OS*(cfg_div+1) clocks.
- cfg_parity  in  2  00 none, 01 even, 10 odd, 11 treated as none.
- cfg_stop2  in  1  0 = one stop bit, 1 = two stop bits (TX only).
- wr_en  in  1  transmit request; accepted only when busy=0.
- data_in  in  DATA_BITS  byte to transmit; sampled on acceptance.
- busy  out  1  transmitter active.
- tx  out  1  serial output; idle high.
- rx  in  1  serial input; asynchronous.
- data_out  out  DATA_BITS  last received word.
- rdy  out  1  received word valid.
- rdy_clr  in  1  clears rdy and all error flags.
- parity_err  out  1  parity mismatch on the last frame.
- frame_err  out  1  first stop bit sampled low.
- overrun  out  1  a frame completed while rdy was still 1.

Behaviour:
- Reset values: tx=1, busy=0, rdy=0, data_out=0, all error flags 0, both FSMs IDLE, rx synchroniser flops preset to 1. Reset mid-frame aborts the frame; outputs take reset values on the next edge.
- Config inputs are only guaranteed while both FSMs are IDLE. A change mid-frame may corrupt that frame but must not hang either FSM.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped when parity is none) -> STOP -> IDLE.
  - wr_en in IDLE latches data_in and clears the TX prescaler.
  - busy=1 and tx=0 from the next cycle.
  - Each bit lasts exactly OS ticks. Data is sent LSB first.
  - Parity bit: even = XOR of data bits; odd = inverted XOR.
  - STOP holds tx=1 for 1 or 2 bit periods. busy falls in the cycle after the last stop bit ends.
  - wr_en while busy=1 is ignored; no queueing.
- RX input: 2-flop synchroniser, then falling-edge detect.
- RX FSM: IDLE -> START -> DATA -> PARITY (if enabled) -> STOP -> IDLE.
  - A falling edge in IDLE clears the RX prescaler and enters START.
  - At OS/2 ticks the line is sampled. If high, it is a false start and the FSM returns to IDLE with no flags set.
  - Each later sample falls OS ticks after the previous one (bit centre). Only the first stop bit is checked, regardless of cfg_stop2.
- Completion (cycle after the stop sample): data_out is loaded, rdy=1, parity_err and frame_err are set from this frame.
  - overrun=1 if rdy was already 1. The new word overwrites data_out; error flags are sticky (OR) until cleared.
- rdy_clr alone: rdy and all flags go to 0.
- rdy_clr in the same cycle as completion: completion wins. rdy=1, flags come from the new frame only, overrun=0.
- After frame_err the RX FSM waits for synced rx=1 before re-arming (break tolerance).
- cfg_div=0 gives one tick per clock; the minimum bit period is OS clocks.
- Frame latency (8N1, cfg_div=D): busy high for 10*OS*(D+1) clocks. In loopback, rdy rises about 9.5*OS*(D+1)+3 clocks after acceptance.

Decomposition:
- Package uart_pkg holds:
  - parity codes PAR_NONE, PAR_EVEN, PAR_ODD
  - TX and RX state encodings
  - default OS constant
- One sub-module, uart_tick_gen: a DIV_W-bit prescaler with synchronous clear, emitting a 1-clock tick pulse. It is instantiated twice, once for TX and once for RX.
- Two sub-modules for TX and RX FSMs are permitted but not required.

Test Plan:
- Loopback tx->rx, cfg_div=3, 8N1, send 0xAB -> busy high exactly 640 clocks; rdy=1, data_out=0xAB, no flags. After rdy_clr, send 0x55 -> data_out=0x55.
- Even parity, bench drives rx with 0x55 and parity bit 1 -> rdy=1, data_out=0x55, parity_err=1, frame_err=0. Odd parity, 0x55, parity bit 1 -> no error.
- Bench drives 0xA5 with stop bit 0 -> frame_err=1. Hold rx low 3 bit periods -> no new rdy. Release, then send 0x3C -> received correctly.
- Two loopback frames 0x11, 0x22 with no rdy_clr -> overrun=1, data_out=0x22. Pulse rdy_clr -> rdy, overrun, parity_err, frame_err all 0.
- rx low for OS/2-2 ticks then high -> no rdy, RX stays IDLE. A valid frame following it is received.
- DATA_BITS=7, odd parity, cfg_stop2=1, send 0x7F -> TX frame 11 bits long with parity bit 0. Assert rst mid-DATA -> tx=1, busy=0 on the next edge. wr_en while busy -> ignored, tx waveform unchanged.
